// File: rtl/avalon_bus_arbiter.sv
// Two-requester Avalon-MM arbiter (fetch = port 0, data = port 1) with a stall watchdog.
// Optional `ARB_ROUND_ROBIN_EN swaps fixed port-1 priority for round-robin on ties.
module avalon_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} ArbState;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  ArbState     r_state;
  ArbState     w_nextState;
  logic        w_req0;
  logic        w_req1;
  logic        w_pick1;
  logic [15:0] r_stallCnt;
  logic [15:0] w_stallInc;
  logic        r_timeoutErr;

  assign w_req0     = m0_read | m0_write;
  assign w_req1     = m1_read | m1_write;
  assign w_stallInc = r_stallCnt + 16'd1;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_lastOwner;

  // On a tie the port that was not served last wins; a lone requester always wins.
  assign w_pick1 = w_req1 & (~w_req0 | ~r_lastOwner);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastOwner <= 1'b0;
    end else if (r_state == IDLE && (w_req0 | w_req1)) begin
      r_lastOwner <= w_pick1;
    end
  end
`else
  assign w_pick1 = w_req1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A granted port dropping its request is treated like completion: back to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick1) begin
          w_nextState = GNT1;
        end else if (w_req0) begin
          w_nextState = GNT0;
        end
      end
      GNT0: begin
        if (!w_req0 || !waitrequest) begin
          w_nextState = IDLE;
        end
      end
      GNT1: begin
        if (!w_req1 || !waitrequest) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    address        = '0;
    read           = 1'b0;
    write          = 1'b0;
    writedata      = '0;
    byteenable     = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (r_state)
      GNT0: begin
        address        = m0_address;
        read           = m0_read;
        write          = m0_write;
        writedata      = m0_writedata;
        byteenable     = m0_byteenable;
        m0_waitrequest = waitrequest;
      end
      GNT1: begin
        address        = m1_address;
        read           = m1_read;
        write          = m1_write;
        writedata      = m1_writedata;
        byteenable     = m1_byteenable;
        m1_waitrequest = waitrequest;
      end
      default: begin
      end
    endcase
  end

  // Stall counter is held at zero while idle so every grant starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt   <= '0;
      r_timeoutErr <= 1'b0;
    end else if (r_state == IDLE) begin
      r_stallCnt <= '0;
    end else if (waitrequest && r_stallCnt != 16'hFFFF) begin
      r_stallCnt <= w_stallInc;
      if (w_stallInc >= TIMEOUT_CNT) begin
        r_timeoutErr <= 1'b1;
      end
    end
  end

  assign grant       = {r_state == GNT1, r_state == GNT0};
  assign timeout_err = r_timeoutErr;
  assign m0_readdata = readdata;
  assign m1_readdata = readdata;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; expectations follow `ARB_ROUND_ROBIN_EN when defined.
module tb_avalon_bus_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int BW         = DW / 8;
  localparam int TB_TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] m0_address, m1_address, address;
  logic          m0_read, m0_write, m1_read, m1_write, read, write;
  logic [DW-1:0] m0_writedata, m1_writedata, writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, byteenable;
  logic          m0_waitrequest, m1_waitrequest, waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata, readdata;
  logic [1:0]    grant;
  logic          timeout_err;

  int checksPassed = 0;
  int checksTotal  = 0;

  avalon_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got still running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic clearInputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    waitrequest = 0; readdata = '0;
  endtask

  // Leaves the bench just after a falling edge with reset released and the DUT idle.
  task automatic resetDut();
    @(negedge clk);
    reset = 1;
    clearInputs();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    m0_read = 1; m1_write = 1; waitrequest = 1; m1_address = 32'h55; m1_writedata = 32'hAA;
    m1_byteenable = 4'hF;
    #1;
    checksTotal++;
    if ({grant, read, write, m0_waitrequest, m1_waitrequest, timeout_err} !== 7'b00_00_11_0)
      $display("[TB] FAIL reset_ctrl: got %b expected %b",
               {grant, read, write, m0_waitrequest, m1_waitrequest, timeout_err}, 7'b00_00_11_0);
    else checksPassed++;
    checksTotal++;
    if ({address, writedata, byteenable} !== '0)
      $display("[TB] FAIL reset_bus: got %h/%h/%h expected 0", address, writedata, byteenable);
    else checksPassed++;
    @(posedge clk); #1;
    checksTotal++;
    if (grant !== 2'b00) $display("[TB] FAIL reset_held_grant: got %b expected 00", grant);
    else checksPassed++;
    @(negedge clk);
    reset = 0;
    clearInputs();
  endtask

  task automatic test_single_read();
    resetDut();
    m0_read = 1; m0_address = 32'hBFC00000; m0_byteenable = 4'hF;
    waitrequest = 0; readdata = 32'h12345678;
    #1;
    checksTotal++;
    if ({grant, read, m0_waitrequest} !== 4'b00_0_1)
      $display("[TB] FAIL t1_idle: got %b expected %b", {grant, read, m0_waitrequest}, 4'b0001);
    else checksPassed++;
    @(negedge clk); #1;
    checksTotal++;
    if ({grant, read, write, m0_waitrequest} !== 5'b01_1_0_0)
      $display("[TB] FAIL t1_granted: got %b expected %b", {grant, read, write, m0_waitrequest}, 5'b01100);
    else checksPassed++;
    checksTotal++;
    if (address !== 32'hBFC00000 || m0_readdata !== 32'h12345678)
      $display("[TB] FAIL t1_data: got %h/%h expected bfc00000/12345678", address, m0_readdata);
    else checksPassed++;
    @(negedge clk);
    m0_read = 0;
    #1;
    checksTotal++;
    if ({grant, read} !== 3'b00_0) $display("[TB] FAIL t1_back_idle: got %b expected 000", {grant, read});
    else checksPassed++;
  endtask

  task automatic test_priority();
    resetDut();
    m0_read = 1; m0_address = 32'h2000;
    m1_write = 1; m1_address = 32'h1000; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
    waitrequest = 0;
    #1;
    checksTotal++;
    if ({grant, m0_waitrequest, m1_waitrequest} !== 4'b00_1_1)
      $display("[TB] FAIL t2_idle: got %b expected 0011", {grant, m0_waitrequest, m1_waitrequest});
    else checksPassed++;
    @(negedge clk); #1;
    checksTotal++;
    if ({grant, read, write, m0_waitrequest, m1_waitrequest} !== 6'b10_0_1_1_0)
      $display("[TB] FAIL t2_m1_ctrl: got %b expected 100110",
               {grant, read, write, m0_waitrequest, m1_waitrequest});
    else checksPassed++;
    checksTotal++;
    if (address !== 32'h1000 || writedata !== 32'hDEADBEEF || byteenable !== 4'hF)
      $display("[TB] FAIL t2_m1_bus: got %h/%h/%h expected 1000/deadbeef/f", address, writedata, byteenable);
    else checksPassed++;
    @(negedge clk);
    m1_write = 0;
    #1;
    checksTotal++;
    if ({grant, m0_waitrequest} !== 3'b00_1)
      $display("[TB] FAIL t2_gap: got %b expected 001", {grant, m0_waitrequest});
    else checksPassed++;
    @(negedge clk); #1;
    checksTotal++;
    if ({grant, read, m0_waitrequest} !== 4'b01_1_0 || address !== 32'h2000)
      $display("[TB] FAIL t2_m0_grant: got %b/%h expected 0110/2000", {grant, read, m0_waitrequest}, address);
    else checksPassed++;
    @(negedge clk);
    m0_read = 0;
  endtask

  task automatic test_wait_states();
    resetDut();
    m1_read = 1; m1_address = 32'h3000; m0_read = 1; m0_address = 32'h4000; waitrequest = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checksTotal++;
      if ({grant, read, m1_waitrequest, m0_waitrequest, timeout_err} !== 6'b10_1_1_1_0)
        $display("[TB] FAIL t3_stall%0d: got %b expected 101110", i,
                 {grant, read, m1_waitrequest, m0_waitrequest, timeout_err});
      else checksPassed++;
      @(negedge clk);
    end
    waitrequest = 0;
    #1;
    checksTotal++;
    if ({grant, read, m1_waitrequest, m0_waitrequest} !== 5'b10_1_0_1)
      $display("[TB] FAIL t3_complete: got %b expected 10101", {grant, read, m1_waitrequest, m0_waitrequest});
    else checksPassed++;
    @(negedge clk);
    m1_read = 0;
    #1;
    checksTotal++;
    if ({grant, timeout_err} !== 3'b00_0) $display("[TB] FAIL t3_gap: got %b expected 000", {grant, timeout_err});
    else checksPassed++;
    @(negedge clk);
    m0_read = 0;
  endtask

  task automatic test_timeout();
    resetDut();
    m0_read = 1; m0_address = 32'h10; waitrequest = 1;
    @(negedge clk);
    for (int i = 1; i <= TB_TIMEOUT; i++) begin
      #1;
      checksTotal++;
      if ({grant, timeout_err} !== 3'b01_0)
        $display("[TB] FAIL t4_before%0d: got %b expected 010", i, {grant, timeout_err});
      else checksPassed++;
      @(negedge clk);
    end
    #1;
    checksTotal++;
    if ({grant, timeout_err} !== 3'b01_1) $display("[TB] FAIL t4_set: got %b expected 011", {grant, timeout_err});
    else checksPassed++;
    @(negedge clk);
    waitrequest = 0;
    @(negedge clk);
    m0_read = 0;
    @(negedge clk); #1;
    checksTotal++;
    if ({grant, timeout_err} !== 3'b00_1) $display("[TB] FAIL t4_sticky: got %b expected 001", {grant, timeout_err});
    else checksPassed++;
    resetDut();
    #1;
    checksTotal++;
    if (timeout_err !== 1'b0) $display("[TB] FAIL t4_cleared: got %b expected 0", timeout_err);
    else checksPassed++;
  endtask

  task automatic test_async_reset();
    resetDut();
    m1_write = 1; m1_address = 32'h80; m1_writedata = 32'h1; waitrequest = 1;
    @(negedge clk); #1;
    checksTotal++;
    if ({grant, write} !== 3'b10_1) $display("[TB] FAIL t5_granted: got %b expected 101", {grant, write});
    else checksPassed++;
    @(posedge clk);
    #3 reset = 1;
    #1;
    checksTotal++;
    if ({grant, read, write, m0_waitrequest, m1_waitrequest, timeout_err} !== 7'b00_0_0_1_1_0)
      $display("[TB] FAIL t5_async: got %b expected 0000110",
               {grant, read, write, m0_waitrequest, m1_waitrequest, timeout_err});
    else checksPassed++;
    @(negedge clk);
    reset = 0;
    clearInputs();
  endtask

  task automatic test_back_to_back();
    logic [1:0] expGrant;
    resetDut();
    m0_read = 1; m1_read = 1; m0_address = 32'hA0; m1_address = 32'hB0; waitrequest = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (i % 2 == 1) expGrant = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      else expGrant = ((i / 2) % 2 == 0) ? 2'b10 : 2'b01;
`else
      else expGrant = 2'b10;
`endif
      checksTotal++;
      if (grant !== expGrant) $display("[TB] FAIL b2b_grant%0d: got %b expected %b", i, grant, expGrant);
      else checksPassed++;
    end
    @(negedge clk);
    clearInputs();
  endtask

  // Requesters raise random transactions and hold them until they see their waitrequest low.
  task automatic test_random();
    bit            pend[2];
    bit            isWr[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wd[2];
    logic [BW-1:0] be[2];
    int            owner;
    bit            lastOwner;
    int            stall;
    bit            err;
    logic [6:0]    expCtrl;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWd;
    logic [BW-1:0] expBe;
    for (int round = 0; round < 4; round++) begin
      resetDut();
      owner = -1; lastOwner = 0; stall = 0; err = 0;
      for (int k = 0; k < 2; k++) pend[k] = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        if (cyc != 0) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          if (!pend[k] && $urandom_range(0, 2) == 0) begin
            pend[k] = 1;
            isWr[k] = 1'($urandom_range(0, 1));
            addr[k] = $urandom;
            wd[k]   = $urandom;
            be[k]   = BW'($urandom_range(0, 15));
          end
        end
        m0_read = pend[0] && !isWr[0]; m0_write = pend[0] && isWr[0];
        m0_address = addr[0]; m0_writedata = wd[0]; m0_byteenable = be[0];
        m1_read = pend[1] && !isWr[1]; m1_write = pend[1] && isWr[1];
        m1_address = addr[1]; m1_writedata = wd[1]; m1_byteenable = be[1];
        waitrequest = ($urandom_range(0, 4) == 0);
        readdata = $urandom;
        #1;
        if (owner >= 0) begin
          expCtrl = {owner == 1, owner == 0, pend[owner] && !isWr[owner], pend[owner] && isWr[owner],
                     (owner == 0) ? waitrequest : 1'b1, (owner == 1) ? waitrequest : 1'b1, err};
          expAddr = addr[owner]; expWd = wd[owner]; expBe = be[owner];
        end else begin
          expCtrl = {4'b0000, 2'b11, err};
          expAddr = '0; expWd = '0; expBe = '0;
        end
        checksTotal++;
        if ({grant, read, write, m0_waitrequest, m1_waitrequest, timeout_err} !== expCtrl)
          $display("[TB] FAIL rnd_ctrl r%0d c%0d: got %b expected %b", round, cyc,
                   {grant, read, write, m0_waitrequest, m1_waitrequest, timeout_err}, expCtrl);
        else checksPassed++;
        checksTotal++;
        if (address !== expAddr || writedata !== expWd || byteenable !== expBe)
          $display("[TB] FAIL rnd_bus r%0d c%0d: got %h/%h/%h expected %h/%h/%h", round, cyc,
                   address, writedata, byteenable, expAddr, expWd, expBe);
        else checksPassed++;
        checksTotal++;
        if (m0_readdata !== readdata || m1_readdata !== readdata)
          $display("[TB] FAIL rnd_rdata r%0d c%0d: got %h/%h expected %h", round, cyc,
                   m0_readdata, m1_readdata, readdata);
        else checksPassed++;
        @(posedge clk);
        if (owner >= 0) begin
          if (waitrequest) begin
            if (stall < 65535) stall++;
            if (stall >= TB_TIMEOUT) err = 1;
          end
          if (!pend[owner]) owner = -1;
          else if (!waitrequest) begin
            pend[owner] = 0;
            owner = -1;
          end
        end else if (pend[0] || pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (pend[0] && pend[1]) owner = lastOwner ? 0 : 1;
          else owner = pend[1] ? 1 : 0;
`else
          owner = pend[1] ? 1 : 0;
`endif
          lastOwner = (owner == 1);
          stall = 0;
        end
      end
    end
    @(negedge clk);
    clearInputs();
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_single_read();
    test_priority();
    test_wait_states();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
